mem_port_arbiter: RTL

Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the RV32I pipeline. Only one transaction is outstanding at a time. Arbitration is data-first, with a starvation guard for fetch and a fetch-kill path for branch/jump flushes. Sits between the pipeline's IF/MEM stages and the memory model/BRAM wrapper.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_arb_prio.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
// Also defines the default bus widths used by the arbiter files.
package mem_port_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Which requester owns the memory in a given busy state.
  function automatic arb_owner_e state_owner(input arb_state_e st);
    arb_owner_e own;
    case (st)
      ARB_BUSY_D: own = OWN_DM;
      default:    own = OWN_IF;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection for the memory port: data-first with a fetch starvation guard.
// A fetch request that is killed in the same cycle never competes.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       if_kill,
  input  logic       dm_req,
  input  logic       idle,
  input  logic       grant_taken,
  output arb_owner_e winner,
  output logic       valid
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_r;
  logic          if_ok_s;
  logic          force_if_s;

  assign if_ok_s    = if_req & ~if_kill;
  assign force_if_s = (starve_cnt_r == LIMIT);

  // Pick the winner among live requests while the port is idle.
  always_comb begin
    winner = OWN_IF;
    valid  = 1'b0;
    if (idle) begin
      if (if_ok_s && dm_req) begin
        valid  = 1'b1;
        winner = force_if_s ? OWN_IF : OWN_DM;
      end else if (dm_req) begin
        valid  = 1'b1;
        winner = OWN_DM;
      end else if (if_ok_s) begin
        valid  = 1'b1;
        winner = OWN_IF;
      end else begin
        valid  = 1'b0;
        winner = OWN_IF;
      end
    end else begin
      valid  = 1'b0;
      winner = OWN_IF;
    end
  end

  // Count data grants that left a fetch waiting; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (grant_taken && (winner == OWN_IF)) begin
      starve_cnt_r <= '0;
    end else if (grant_taken && (winner == OWN_DM) && if_req && !force_if_s) begin
      starve_cnt_r <= starve_cnt_r + 1'b1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and MEM stages.
// Optional watchdog enabled by defining MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr_i,
  input  logic                      if_kill_i,
  output logic                      if_gnt_o,
  output logic                      if_rvalid_o,
  output logic [DATA_WIDTH-1:0]     if_rdata_o,
  input  logic                      dm_req_i,
  input  logic                      dm_we_i,
  input  logic [DATA_WIDTH/8-1:0]   dm_be_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0]     dm_wdata_i,
  output logic                      dm_gnt_o,
  output logic                      dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]     dm_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      err_o
);

  localparam int BW = DATA_WIDTH / 8;

  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 2 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("mem_port_arbiter: unsupported parameter set");
  end

  arb_state_e                state_r;
  logic                      we_r;
  logic [BW-1:0]             be_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0]     wdata_r;
  logic                      kill_r;

  logic       idle_s;
  logic       busy_s;
  logic       ack_s;
  logic       tmo_s;
  logic       done_s;
  logic       prio_valid_s;
  arb_owner_e winner_s;
  arb_owner_e owner_s;

  // Reset masks every output combinationally so nothing leaks during rst.
  assign idle_s  = (state_r == ARB_IDLE) & ~rst;
  assign busy_s  = (state_r != ARB_IDLE) & ~rst;
  assign ack_s   = busy_s & mem_ack_i;
  assign owner_s = state_owner(state_r);

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req_i),
    .if_kill    (if_kill_i),
    .dm_req     (dm_req_i),
    .idle       (idle_s),
    .grant_taken(prio_valid_s),
    .winner     (winner_s),
    .valid      (prio_valid_s)
  );

  assign if_gnt_o = prio_valid_s & (winner_s == OWN_IF);
  assign dm_gnt_o = prio_valid_s & (winner_s == OWN_DM);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_r;
  logic          err_r;

  assign tmo_s = busy_s & ~mem_ack_i & (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign err_o = err_r | tmo_s;

  // Watchdog counts busy cycles; it restarts each time the port goes busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
      err_r     <= 1'b0;
    end else begin
      if (!busy_s || done_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end
      if (tmo_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end
`else
  assign tmo_s = 1'b0;
  assign err_o = 1'b0;
`endif

  assign done_s = ack_s | tmo_s;

  assign mem_req_o   = busy_s & ~tmo_s;
  assign mem_we_o    = busy_s & we_r;
  assign mem_be_o    = busy_s ? be_r : {BW{1'b0}};
  assign mem_addr_o  = busy_s ? addr_r : {MEM_ADDR_WIDTH{1'b0}};
  assign mem_wdata_o = busy_s ? wdata_r : {DATA_WIDTH{1'b0}};

  // A fetch killed earlier or in the ack cycle itself must not reach the pipeline.
  assign if_rvalid_o = done_s & (state_r == ARB_BUSY_I) & ~kill_r & ~if_kill_i;
  assign dm_rvalid_o = done_s & (owner_s == OWN_DM);
  assign if_rdata_o  = ack_s ? mem_rdata_i : {DATA_WIDTH{1'b0}};
  assign dm_rdata_o  = ack_s ? mem_rdata_i : {DATA_WIDTH{1'b0}};

  // Port state machine with payload capture at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      we_r    <= 1'b0;
      be_r    <= {BW{1'b0}};
      addr_r  <= {MEM_ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      kill_r  <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          kill_r <= 1'b0;
          if (if_gnt_o) begin
            state_r <= ARB_BUSY_I;
            we_r    <= 1'b0;
            be_r    <= {BW{1'b1}};
            addr_r  <= if_addr_i;
            wdata_r <= {DATA_WIDTH{1'b0}};
          end else if (dm_gnt_o) begin
            state_r <= ARB_BUSY_D;
            we_r    <= dm_we_i;
            be_r    <= dm_be_i;
            addr_r  <= dm_addr_i;
            wdata_r <= dm_wdata_i;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_BUSY_I: begin
          if (done_s) begin
            state_r <= ARB_IDLE;
            kill_r  <= 1'b0;
          end else begin
            state_r <= ARB_BUSY_I;
            kill_r  <= kill_r | if_kill_i;
          end
        end
        ARB_BUSY_D: begin
          if (done_s) begin
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY_D;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
